tx_payload_crc_fifo_param: RTL and testbench

Parametrised TX payload buffer plus CRC appender for the BLE PHY transmit path. It collects serial payload bits into an internal bit FIFO. On a start strobe it replays the stored payload, then appends a CRC_W-bit CRC computed over that payload, MSB first. Polynomial, CRC width, FIFO depth and CRC enable are configurable; the previous fixed 24-bit/4096-deep block becomes one instance (CRC_W=24, ADDR_W=12).

---
 rtl/tx_payload_crc_fifo_param_if.sv | 30 +++
 rtl/tx_payload_crc_fifo_param.sv | 182 ++++++++++++++++++
 tb/tb_tx_payload_crc_fifo_param.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_payload_crc_fifo_param_if.sv
// Bus bundle for the TX payload buffer / CRC appender: payload input,
// start controls and serial output with status.
interface tx_payload_crc_fifo_param_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CRC_W  = 24
);
    logic              valid_in;
    logic              data_in;
    logic              enable;
    logic              crc_en;
    logic [CRC_W-1:0]  crc_init;
    logic              data_out;
    logic              valid_out;
    logic              flag;
    logic              finished;
    logic              busy;
    logic              full;
    logic              overflow;
    logic [ADDR_W+1:0] num_after_crc;

    modport master (
        output valid_in, data_in, enable, crc_en, crc_init,
        input  data_out, valid_out, flag, finished, busy, full, overflow, num_after_crc
    );

    modport slave (
        input  valid_in, data_in, enable, crc_en, crc_init,
        output data_out, valid_out, flag, finished, busy, full, overflow, num_after_crc
    );
endinterface

// File: rtl/tx_payload_crc_fifo_param.sv
// Bit FIFO that collects a payload and, on start, replays it serially
// followed by an optional CRC_W-bit CRC computed over the payload (MSB first).
module tx_payload_crc_fifo_param #(
    parameter int unsigned      ADDR_W   = 12,
    parameter int unsigned      CRC_W    = 24,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(24'h00065B)
) (
    input  logic                       clk,
    input  logic                       reset,
    tx_payload_crc_fifo_param_if.slave bus
);
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned NUM_W  = ADDR_W + 2;
    localparam int unsigned CRC_CW = $clog2(CRC_W + 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CRC, DONE} state_e;

    state_e            state_q, state_d;
    logic [DEPTH-1:0]  mem_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  len_rem_q, len_rem_d;
    logic [CRC_CW-1:0] crc_rem_q, crc_rem_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic              mode_q, mode_d;
    logic              overflow_q, overflow_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic              data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic              flag_q, flag_d;
    logic              finished_q, finished_d;
    logic              busy_q, busy_d;
    logic              full_q, full_d;
    logic              we_c;
    logic              pop_bit_c;
    logic              fb_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            len_q       <= '0;
            len_rem_q   <= '0;
            crc_rem_q   <= '0;
            crc_q       <= '0;
            mode_q      <= 1'b0;
            overflow_q  <= 1'b0;
            num_q       <= '0;
            data_out_q  <= 1'b0;
            valid_out_q <= 1'b0;
            flag_q      <= 1'b0;
            finished_q  <= 1'b0;
            busy_q      <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            len_q       <= len_d;
            len_rem_q   <= len_rem_d;
            crc_rem_q   <= crc_rem_d;
            crc_q       <= crc_d;
            mode_q      <= mode_d;
            overflow_q  <= overflow_d;
            num_q       <= num_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            flag_q      <= flag_d;
            finished_q  <= finished_d;
            busy_q      <= busy_d;
            full_q      <= full_d;
        end
    end

    // Payload storage has no reset; emptiness is carried by the pointers/count.
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        len_d       = len_q;
        len_rem_d   = len_rem_q;
        crc_rem_d   = crc_rem_q;
        crc_d       = crc_q;
        mode_d      = mode_q;
        overflow_d  = overflow_q;
        num_d       = num_q;
        data_out_d  = 1'b0;
        valid_out_d = 1'b0;
        flag_d      = 1'b0;
        finished_d  = 1'b0;
        we_c        = 1'b0;
        pop_bit_c   = mem_q[rd_ptr_q];
        fb_c        = crc_q[CRC_W-1] ^ pop_bit_c;

        case (state_q)
            IDLE: begin
                if (bus.enable && (count_q != '0)) begin
                    // A write colliding with start is lost; its flag beats the start clear.
                    state_d    = PAYLOAD;
                    len_d      = count_q;
                    len_rem_d  = count_q;
                    crc_d      = bus.crc_init;
                    mode_d     = bus.crc_en;
                    overflow_d = bus.valid_in;
                end else if (bus.valid_in) begin
                    if (full_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        we_c     = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                valid_out_d = 1'b1;
                data_out_d  = pop_bit_c;
                rd_ptr_d    = rd_ptr_q + 1'b1;
                count_d     = count_q - 1'b1;
                len_rem_d   = len_rem_q - 1'b1;
                crc_d       = {crc_q[CRC_W-2:0], 1'b0} ^ (fb_c ? CRC_POLY : '0);
                if (bus.valid_in) begin
                    overflow_d = 1'b1;
                end
                if (len_rem_q == CNT_W'(1)) begin
                    state_d   = mode_q ? CRC : DONE;
                    crc_rem_d = CRC_CW'(CRC_W);
                end
            end
            CRC: begin
                valid_out_d = 1'b1;
                flag_d      = 1'b1;
                data_out_d  = crc_q[CRC_W-1];
                crc_d       = {crc_q[CRC_W-2:0], 1'b0};
                crc_rem_d   = crc_rem_q - 1'b1;
                if (bus.valid_in) begin
                    overflow_d = 1'b1;
                end
                if (crc_rem_q == CRC_CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                finished_d = 1'b1;
                num_d      = NUM_W'(len_q) + (mode_q ? NUM_W'(CRC_W) : NUM_W'(0));
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                count_d    = '0;
                state_d    = IDLE;
                if (bus.valid_in) begin
                    overflow_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == PAYLOAD) || (state_d == CRC);
        full_d = (count_d == CNT_W'(DEPTH));
    end

    assign bus.data_out      = data_out_q;
    assign bus.valid_out     = valid_out_q;
    assign bus.flag          = flag_q;
    assign bus.finished      = finished_q;
    assign bus.busy          = busy_q;
    assign bus.full          = full_q;
    assign bus.overflow      = overflow_q;
    assign bus.num_after_crc = num_q;
endmodule

// File: tb/tb_tx_payload_crc_fifo_param.sv
// Bench: a default 24-bit/4096-deep instance and a small CRC-8/8-deep instance
// sharing stimulus; the active one is chosen by sel and checked against a model.
module tb_tx_payload_crc_fifo_param;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        valid_in = 1'b0;
    logic        data_in = 1'b0;
    logic        enable = 1'b0;
    logic        crc_en = 1'b0;
    logic [23:0] crc_init = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tx_payload_crc_fifo_param_if #(.ADDR_W(12), .CRC_W(24)) a_if ();
    tx_payload_crc_fifo_param_if #(.ADDR_W(3),  .CRC_W(8))  b_if ();

    tx_payload_crc_fifo_param #(.ADDR_W(12), .CRC_W(24), .CRC_POLY(24'h00065B)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave));
    tx_payload_crc_fifo_param #(.ADDR_W(3), .CRC_W(8), .CRC_POLY(8'h07)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave));

    assign a_if.valid_in = valid_in & ~sel;
    assign a_if.data_in  = data_in;
    assign a_if.enable   = enable & ~sel;
    assign a_if.crc_en   = crc_en;
    assign a_if.crc_init = crc_init;
    assign b_if.valid_in = valid_in & sel;
    assign b_if.data_in  = data_in;
    assign b_if.enable   = enable & sel;
    assign b_if.crc_en   = crc_en;
    assign b_if.crc_init = crc_init[7:0];

    logic        o_valid, o_data, o_flag, o_fin, o_busy, o_full, o_ovf;
    logic [13:0] o_num;
    assign o_valid = sel ? b_if.valid_out : a_if.valid_out;
    assign o_data  = sel ? b_if.data_out  : a_if.data_out;
    assign o_flag  = sel ? b_if.flag      : a_if.flag;
    assign o_fin   = sel ? b_if.finished  : a_if.finished;
    assign o_busy  = sel ? b_if.busy      : a_if.busy;
    assign o_full  = sel ? b_if.full      : a_if.full;
    assign o_ovf   = sel ? b_if.overflow  : a_if.overflow;
    assign o_num   = sel ? 14'(b_if.num_after_crc) : a_if.num_after_crc;

    typedef struct {
        logic        s;
        int          n;
        logic [15:0] bits;
        logic        ce;
        logic [23:0] init;
        logic [23:0] crc;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // CRC as defined: shift left, XOR the generator when (msb ^ message bit) is set.
    function automatic logic [23:0] crc_ref(input logic pay[$], input logic [23:0] init,
                                            input int w, input logic [23:0] poly);
        longint unsigned c;
        longint unsigned mask;
        longint unsigned top;
        mask = (64'(1) << w) - 1;
        c = init & mask;
        foreach (pay[i]) begin
            top = (c >> (w - 1)) & 1;
            c = (c << 1) & mask;
            if (top != 64'(pay[i])) c = c ^ 64'(poly);
        end
        return 24'(c);
    endfunction

    task automatic write_bits(input logic s, input logic b[$]);
        sel = s;
        foreach (b[k]) begin
            valid_in = 1'b1;
            data_in  = b[k];
            tick();
        end
        valid_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic start_and_check(input logic s, input logic pay[$], input logic ce,
                                   input logic [23:0] init, input logic start_wr,
                                   input int mid_en, input logic [23:0] exp_crc,
                                   input string tag);
        int w = s ? 8 : 24;
        int n_exp;
        int n_got = 0;
        int cycles = 0;
        logic seen_fin = 1'b0;
        logic [63:0] exp_d = '0;
        logic [63:0] exp_f = '0;
        logic [63:0] got_d = '0;
        logic [63:0] got_f = '0;
        foreach (pay[k]) begin
            exp_d = {exp_d[62:0], pay[k]};
            exp_f = {exp_f[62:0], 1'b0};
        end
        if (ce) begin
            for (int k = w - 1; k >= 0; k--) begin
                exp_d = {exp_d[62:0], exp_crc[k]};
                exp_f = {exp_f[62:0], 1'b1};
            end
        end
        n_exp = pay.size() + (ce ? w : 0);

        sel = s;
        crc_en = ce;
        crc_init = init;
        enable = 1'b1;
        if (start_wr) begin
            valid_in = 1'b1;
            data_in  = 1'b1;
        end
        tick();
        enable   = 1'b0;
        valid_in = 1'b0;
        crc_en   = ~ce;
        crc_init = ~init;
        chk({tag, " busy@start"}, 64'(o_busy), 64'(1));
        chk({tag, " ovf@start"}, 64'(o_ovf), 64'(start_wr));

        while (!seen_fin && cycles < 200) begin
            if (mid_en > 0 && cycles == mid_en) begin
                enable   = 1'b1;
                valid_in = 1'b1;
            end
            tick();
            enable   = 1'b0;
            valid_in = 1'b0;
            cycles++;
            if (o_valid) begin
                got_d = {got_d[62:0], o_data};
                got_f = {got_f[62:0], o_flag};
                n_got++;
            end
            if (o_fin) seen_fin = 1'b1;
        end
        chk({tag, " finished"}, 64'(seen_fin), 64'(1));
        chk({tag, " data"}, got_d, exp_d);
        chk({tag, " flag"}, got_f, exp_f);
        chk({tag, " bitcount"}, 64'(n_got), 64'(n_exp));
        chk({tag, " latency"}, 64'(cycles), 64'(n_exp + 1));
        chk({tag, " num_after_crc"}, 64'(o_num), 64'(n_exp));
        chk({tag, " ovf@end"}, 64'(o_ovf), 64'(start_wr || mid_en > 0));
        tick();
        chk({tag, " idle"}, 64'({o_busy, o_fin, o_valid, o_flag, o_full}), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic q[$];
        logic [23:0] init;
        logic [23:0] ecrc;
        logic ce;
        logic s;
        int n;
        int mid;
        logic swr;
        logic acc;

        tbl[0] = '{1'b0, 1, 16'h0001, 1'b1, 24'h000000, 24'h00065B};
        tbl[1] = '{1'b0, 8, 16'h0000, 1'b1, 24'h000000, 24'h000000};
        tbl[2] = '{1'b0, 4, 16'h000B, 1'b0, 24'h000000, 24'h000000};
        tbl[3] = '{1'b0, 1, 16'h0000, 1'b1, 24'h800000, 24'h00065B};
        tbl[4] = '{1'b1, 8, 16'h0001, 1'b1, 24'h000000, 24'h000007};
        tbl[5] = '{1'b1, 1, 16'h0000, 1'b1, 24'h000080, 24'h000007};
        tbl[6] = '{1'b1, 2, 16'h0003, 1'b1, 24'h000000, 24'h000009};

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        sel = 1'b0;
        chk("reset outputs A", 64'({o_valid, o_data, o_flag, o_fin, o_busy, o_full, o_ovf}), 64'(0));
        chk("reset num A", 64'(o_num), 64'(0));
        sel = 1'b1;
        chk("reset outputs B", 64'({o_valid, o_data, o_flag, o_fin, o_busy, o_full, o_ovf}), 64'(0));

        // Start with an empty FIFO must do nothing.
        sel = 1'b0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        acc = 1'b0;
        repeat (5) begin
            acc = acc | o_busy | o_valid | o_fin;
            tick();
        end
        chk("empty start", 64'(acc), 64'(0));

        for (int i = 0; i < 7; i++) begin
            q.delete();
            for (int k = tbl[i].n - 1; k >= 0; k--) q.push_back(tbl[i].bits[k]);
            write_bits(tbl[i].s, q);
            start_and_check(tbl[i].s, q, tbl[i].ce, tbl[i].init, 1'b0, 0, tbl[i].crc,
                            $sformatf("tbl%0d", i));
        end

        // Fill the 8-deep instance, drop a ninth write, then send exactly 8 bits.
        sel = 1'b1;
        q.delete();
        for (int k = 0; k < 8; k++) begin
            q.push_back(1'($urandom_range(0, 1)));
            valid_in = 1'b1;
            data_in  = q[k];
            tick();
        end
        chk("full after 8", 64'({o_full, o_ovf}), 64'(2'b10));
        data_in = 1'b1;
        tick();
        valid_in = 1'b0;
        chk("overflow after 9", 64'({o_full, o_ovf}), 64'(2'b11));
        init = 24'($urandom_range(0, 255));
        start_and_check(1'b1, q, 1'b1, init, 1'b0, 0, crc_ref(q, init, 8, 24'h07), "ovf_frame");

        // Enable and a write during PAYLOAD are ignored / flagged.
        q.delete();
        for (int k = 0; k < 10; k++) q.push_back(1'($urandom_range(0, 1)));
        write_bits(1'b0, q);
        start_and_check(1'b0, q, 1'b1, 24'h123456, 1'b0, 4,
                        crc_ref(q, 24'h123456, 24, 24'h00065B), "mid_en");

        // Write colliding with start is dropped and flagged.
        q.delete();
        q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b0);
        write_bits(1'b1, q);
        start_and_check(1'b1, q, 1'b1, 24'h0000A5, 1'b1, 0,
                        crc_ref(q, 24'h0000A5, 8, 24'h07), "start_wr");

        // Reset during the CRC phase.
        q.delete();
        q.push_back(1'b1); q.push_back(1'b1);
        write_bits(1'b0, q);
        crc_en = 1'b1;
        crc_init = 24'h000000;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (7) tick();
        chk("in crc phase", 64'({o_flag, o_busy}), 64'(2'b11));
        reset = 1'b1;
        tick();
        chk("reset mid-crc", 64'({o_valid, o_flag, o_busy, o_full, o_fin}), 64'(0));
        reset = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        acc = 1'b0;
        repeat (30) begin
            acc = acc | o_busy | o_valid | o_fin;
            tick();
        end
        chk("empty after reset", 64'(acc), 64'(0));

        // Randomized frames against the reference model.
        for (int r = 0; r < 24; r++) begin
            s   = 1'($urandom_range(0, 1));
            n   = s ? $urandom_range(1, 8) : $urandom_range(1, 12);
            ce  = 1'($urandom_range(0, 3) != 0);
            init = s ? 24'($urandom_range(0, 255)) : 24'($urandom & 32'h00FF_FFFF);
            swr = 1'($urandom_range(0, 3) == 0);
            mid = (n >= 3 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : 0;
            q.delete();
            for (int k = 0; k < n; k++) q.push_back(1'($urandom_range(0, 1)));
            ecrc = s ? crc_ref(q, init, 8, 24'h07) : crc_ref(q, init, 24, 24'h00065B);
            write_bits(s, q);
            start_and_check(s, q, ce, init, swr, mid, ecrc, $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
